// File: rtl/nibble_serial_alu.sv
// Nibble-serial add/subtract controller around an external 4-bit adder.
// Ports: clk, rst (async high), start/busy/done handshake, op, cin, a, b,
//   result/cout/ovf outputs, and add_* drive/return to the 4-bit adder.
module nibble_serial_alu #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic [3:0]   add_A,
  output logic [3:0]   add_B,
  output logic         add_Cin,
  output logic         add_Contr,
  input  logic [3:0]   add_Sum,
  input  logic         add_Cout
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] LAST = KW'(NIBBLES - 1);
  localparam logic [W-1:0] NIB_MASK = W'(4'hF);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          op_q, op_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [KW+1:0] sh;
  logic          a_msb, b_msb, r_msb;

  // bit offset of the active nibble
  assign sh = {k_q, 2'b00};

  assign a_msb = a_q[W-1];
  assign b_msb = b_q[W-1];
  assign r_msb = result_d[W-1];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    k_d      = k_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = cin;
          k_d     = '0;
        end
      end
      RUN: begin
        result_d = (result_q & ~(NIB_MASK << sh))
                 | (W'(add_Sum) << sh);
        carry_d  = add_Cout;
        k_d      = k_q + KW'(1);
        if (k_q == LAST) begin
          state_d = IDLE;
          k_d     = '0;
          cout_d  = add_Cout;
          done_d  = 1'b1;
          // sign rule differs for add and subtract
          ovf_d   = op_q ? ((a_msb != b_msb) && (r_msb != a_msb))
                         : ((a_msb == b_msb) && (r_msb != a_msb));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      k_q      <= k_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

  // adder drives come only from registers; forced to 0 in IDLE
  assign add_A     = busy ? 4'(a_q >> sh) : 4'd0;
  assign add_B     = busy ? 4'(b_q >> sh) : 4'd0;
  assign add_Cin   = busy & carry_q;
  assign add_Contr = busy & op_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Bench for nibble_serial_alu with a behavioural 4-bit adder model.
// Vector table, random ops vs. a wide-arithmetic model, handshake, reset.
module tb_nibble_serial_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [15:0] result;
  logic [3:0]  add_A, add_B, add_Sum;
  logic        add_Cin, add_Contr, add_Cout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nibble_serial_alu #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .cout(cout), .ovf(ovf), .add_A(add_A), .add_B(add_B),
    .add_Cin(add_Cin), .add_Contr(add_Contr),
    .add_Sum(add_Sum), .add_Cout(add_Cout)
  );

  // 4-bit adder/subtractor: carry on add, borrow on subtract
  logic [4:0] add_t;
  assign add_t = add_Contr
    ? ({1'b0, add_A} - {1'b0, add_B} - {4'd0, add_Cin})
    : ({1'b0, add_A} + {1'b0, add_B} + {4'd0, add_Cin});
  assign add_Sum  = add_t[3:0];
  assign add_Cout = add_t[4];

  typedef struct {
    logic        o;
    logic        c;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // whole-word reference: 17-bit arithmetic, sign rule on MSBs
  task automatic model(input logic o, c, input logic [15:0] x, y,
                       output logic [15:0] r, output logic co, ov);
    logic [16:0] w;
    if (o) w = {1'b0, x} - {1'b0, y} - {16'd0, c};
    else   w = {1'b0, x} + {1'b0, y} + {16'd0, c};
    r  = w[15:0];
    co = w[16];
    if (o) ov = (x[15] != y[15]) && (r[15] != x[15]);
    else   ov = (x[15] == y[15]) && (r[15] != x[15]);
  endtask

  // issue one op at a negedge, watch 12 cycles
  task automatic do_op(input logic o, c, input logic [15:0] x, y,
                       output logic [15:0] r, output logic co, ov,
                       output int nbusy, output int ndone);
    op = o; cin = c; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = $urandom; cin = $urandom;
    nbusy = 0; ndone = 0; r = 'x; co = 1'bx; ov = 1'bx;
    if (busy) nbusy++;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        r = result; co = cout; ov = ovf;
      end
    end
  endtask

  vec_t vt[8];
  logic [15:0] r, er;
  logic co, ov, eco, eov;
  int nb, nd;

  initial begin
    vt[0] = '{1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
    vt[7] = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_adder", {add_A, add_B, add_Cin, add_Contr}, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vt[i]) begin
      do_op(vt[i].o, vt[i].c, vt[i].x, vt[i].y, r, co, ov, nb, nd);
      chk($sformatf("vec%0d_result", i), r, vt[i].r);
      chk($sformatf("vec%0d_cout", i), co, vt[i].co);
      chk($sformatf("vec%0d_ovf", i), ov, vt[i].ov);
      chk($sformatf("vec%0d_busy_cycles", i), nb, 4);
      chk($sformatf("vec%0d_done_cycles", i), nd, 1);
    end
    chk("hold_result", result, vt[7].r);

    for (int t = 0; t < 40; t++) begin
      logic o, c;
      logic [15:0] x, y;
      o = 1'($urandom); c = 1'($urandom);
      x = 16'($urandom); y = 16'($urandom);
      if (t < 4) x = {t[0], 15'h7FFF};
      model(o, c, x, y, er, eco, eov);
      do_op(o, c, x, y, r, co, ov, nb, nd);
      chk($sformatf("rnd%0d_result", t), r, er);
      chk($sformatf("rnd%0d_cout", t), co, eco);
      chk($sformatf("rnd%0d_ovf", t), ov, eov);
      chk($sformatf("rnd%0d_done", t), nd, 1);
    end

    // start during RUN and on the completion edge is ignored
    op = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    chk("hs_busy", busy, 1);
    a = 16'hAAAA; b = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("hs_done", done, 1);
    chk("hs_result", result, 16'h3333);
    chk("hs_no_accept", busy, 0);
    start = 1'b0;
    nb = 0; nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
    chk("hs_idle_busy", nb, 0);
    chk("hs_idle_done", nd, 0);
    do_op(1'b0, 1'b0, 16'hAAAA, 16'h5555, r, co, ov, nb, nd);
    chk("hs_fresh", r, 16'hFFFF);

    // back-to-back: start in the cycle right after done
    op = 1'b0; cin = 1'b0; a = 16'h0010; b = 16'h0020; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_done1", done, 1);
    a = 16'h0100; b = 16'h0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    repeat (4) @(negedge clk);
    chk("b2b_done2", {done, result}, {1'b1, 16'h0300});

    // reset mid-operation at k=2
    do_op(1'b0, 1'b0, 16'h0F0F, 16'h0101, r, co, ov, nb, nd);
    op = 1'b0; a = 16'h8888; b = 16'h8888; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outs", {done, result, cout, ovf}, 0);
    chk("mid_rst_adder", {add_A, add_B, add_Cin, add_Contr}, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    do_op(1'b0, 1'b0, 16'h0101, 16'h0101, r, co, ov, nb, nd);
    chk("post_rst_result", r, 16'h0202);
    chk("post_rst_done", nd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/nibble_serial_alu.md
Name: nibble_serial_alu

Overview:
- Sequential controller that performs NIBBLES*4-bit add/subtract one nibble per clock, using the team's 4-bit combinational adder/subtractor (Parallel_Adder).
- Sits directly around that adder: drives its A, B, Cin and Contr ports and consumes its Sum and Cout outputs.
- Chains the carry/borrow between nibbles and assembles the wide result, final carry/borrow and signed overflow.
- Provides a start/busy/done handshake to the upstream requester.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand. Operand width W = 4*NIBBLES. Legal range is 1 to 16.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add (A+B+cin), 1 = subtract (A-B-cin)
- cin  input  1  carry-in (add) or borrow-in (subtract) for nibble 0
- a  input  W  operand A
- b  input  W  operand B
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle
- result  output  W  assembled sum/difference
- cout  output  1  final carry (add) or borrow (subtract)
- ovf  output  1  two's-complement overflow of the W-bit operation
- add_A  output  4  to adder A
- add_B  output  4  to adder B
- add_Cin  output  1  to adder Cin
- add_Contr  output  1  to adder Contr (1 = subtract)
- add_Sum  input  4  from adder Sum
- add_Cout  input  1  from adder Cout (carry on add, borrow on subtract)

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - All outputs and internal registers go to 0, and the state goes to IDLE.
  - Any in-progress operation is discarded; no done pulse is produced for it.
- States:
  - IDLE: busy = 0, and add_* outputs are 0.
  - IDLE → RUN on a rising edge with start = 1. That same edge:
    - latches a, b, op and cin into internal registers;
    - clears the nibble index k to 0;
    - loads the chain carry register with cin;
    - sets busy = 1.
  - RUN, cycle for index k: the adder drives are purely registered. add_A = a_reg[4k+3:4k], add_B = b_reg[4k+3:4k], add_Cin = chain carry, add_Contr = op_reg.
  - RUN, each rising edge:
    - result[4k+3:4k] <= add_Sum;
    - chain carry <= add_Cout;
    - k <= k+1.
  - RUN → IDLE on the edge that captures nibble NIBBLES-1. That edge:
    - sets cout = add_Cout;
    - computes ovf from a_reg MSB, b_reg MSB and the final result MSB:
      - add: ovf = (aMSB == bMSB) && (resMSB != aMSB);
      - subtract: ovf = (aMSB != bMSB) && (resMSB != aMSB);
    - sets done = 1 for exactly one cycle;
    - sets busy = 0.
- Latency: start sampled at edge E0; done, result, cout and ovf are valid after edge E(NIBBLES). Throughput is one operation per NIBBLES+1 cycles minimum.
- result, cout and ovf hold their values until the next operation's first capture edge. Partial nibbles of result are overwritten in place during RUN.
- start while busy: ignored and not queued. a, b, op and cin may change freely during RUN without effect.
- start high on the same edge that busy falls (completion edge): ignored. start is accepted only in IDLE, so back-to-back operations need start in the cycle after done or later.
- Continuous start in IDLE: one operation per acceptance.
- Arithmetic: all values are modulo 2^W. Subtract borrow semantics follow the adder: a nibble borrow is 1 when a_nib - b_nib - borrow_in < 0.
- NIBBLES = 1: a single RUN cycle.

Test Plan:
- All cases use NIBBLES=4.
- add, a=0x1234, b=0x0FFF, cin=0 → after 4 RUN edges result=0x2233, cout=0, ovf=0, done high exactly 1 cycle, busy high exactly 4 cycles.
- add, a=0xFFFF, b=0x0001, cin=0 → result=0x0000, cout=1, ovf=0. Then add, a=0x7FFF, b=0x0001 → result=0x8000, cout=0, ovf=1.
- sub, a=0x0005, b=0x0007, cin=0 → result=0xFFFE, cout=1, ovf=0. Then sub, a=0x8000, b=0x0001 → result=0x7FFF, cout=0, ovf=1.
- cin checks:
  - add, a=0x0000, b=0x0000, cin=1 → result=0x0001, cout=0;
  - sub, a=0x0000, b=0x0000, cin=1 → result=0xFFFF, cout=1.
- Handshake: start 0x1111+0x2222, then pulse start with 0xAAAA+0x5555 during RUN and again on the completion edge → only 0x3333 is produced. A fresh start the cycle after done yields 0xFFFF.
- Reset at RUN k=2 → busy, done, result, cout, ovf and add_* are immediately 0, no done pulse occurs, and a subsequent add 0x0101+0x0101 gives 0x0202.
